// File: rtl/slab_alloc_mc_if.sv
// Request/response bundle for the slab allocator: alloc channels and free channels.
interface slab_alloc_mc_if #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_ALLOC_CH = 2,
  parameter int unsigned NUM_FREE_CH  = 2
);
  logic [NUM_ALLOC_CH-1:0]        alloc_req_val;
  logic [NUM_ALLOC_CH-1:0]        alloc_req_rdy;
  logic [NUM_ALLOC_CH-1:0]        alloc_resp_val;
  logic [NUM_ALLOC_CH-1:0]        alloc_resp_error;
  logic [NUM_ALLOC_CH*ADDR_W-1:0] alloc_resp_addr;
  logic [NUM_ALLOC_CH-1:0]        alloc_resp_rdy;
  logic [NUM_FREE_CH-1:0]         free_req_val;
  logic [NUM_FREE_CH*ADDR_W-1:0]  free_req_addr;
  logic [NUM_FREE_CH-1:0]         free_req_rdy;

  modport master (
    output alloc_req_val, alloc_resp_rdy, free_req_val, free_req_addr,
    input  alloc_req_rdy, alloc_resp_val, alloc_resp_error, alloc_resp_addr, free_req_rdy
  );

  modport slave (
    input  alloc_req_val, alloc_resp_rdy, free_req_val, free_req_addr,
    output alloc_req_rdy, alloc_resp_val, alloc_resp_error, alloc_resp_addr, free_req_rdy
  );
endinterface

// File: rtl/slab_alloc_mc.sv
// Multi-channel slab allocator: bitmap of fixed-size slabs, round-robin alloc and
// free arbitration, illegal frees reported instead of applied.
module slab_alloc_mc #(
  parameter int unsigned NUM_SLABS    = 16,
  parameter int unsigned SLAB_BYTES   = 64,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_ALLOC_CH = 2,
  parameter int unsigned NUM_FREE_CH  = 2,
  parameter int unsigned CNT_W        = $clog2(NUM_SLABS + 1),
  parameter int unsigned ERR_CH_W     = (NUM_FREE_CH > 1) ? $clog2(NUM_FREE_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  slab_alloc_mc_if.slave      bus,
  output logic                free_err_val,
  output logic [1:0]          free_err_cause,
  output logic [ERR_CH_W-1:0] free_err_ch,
  output logic [CNT_W-1:0]    free_count
);
  localparam int unsigned ACH_W = (NUM_ALLOC_CH > 1) ? $clog2(NUM_ALLOC_CH) : 1;
  localparam int unsigned SHIFT = $clog2(SLAB_BYTES);
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(SLAB_BYTES - 1);
  localparam logic [ADDR_W-1:0] NSLAB = ADDR_W'(NUM_SLABS);

  logic [NUM_SLABS-1:0]    bitmap;
  logic [NUM_ALLOC_CH-1:0] a_elig;
  logic [ACH_W-1:0]        a_ptr, a_win;
  logic                    a_found;
  logic [ERR_CH_W-1:0]     f_ptr, f_win;
  logic                    f_found;
  logic                    s_found;
  logic [NUM_SLABS-1:0]    s_onehot;
  logic [ADDR_W-1:0]       s_addr;
  logic [ADDR_W-1:0]       f_addr, f_off, f_slot;
  logic                    f_borrow;
  logic [NUM_SLABS-1:0]    f_hit;
  logic                    f_mis, f_oor, f_dbl, f_bad, f_ok;
  logic [NUM_SLABS-1:0]    set_mask, clr_mask;

  // A channel with an unconsumed response cannot be granted again.
  assign a_elig = bus.alloc_req_val & ~bus.alloc_resp_val;

  // Round-robin: first eligible at or above the pointer, else wrap to lowest.
  always_comb begin
    a_found = 1'b0;
    a_win   = '0;
    for (int c = 0; c < int'(NUM_ALLOC_CH); c++)
      if (!a_found && a_elig[c] && (ACH_W'(c) >= a_ptr)) begin
        a_found = 1'b1;
        a_win   = ACH_W'(c);
      end
    for (int c = 0; c < int'(NUM_ALLOC_CH); c++)
      if (!a_found && a_elig[c]) begin
        a_found = 1'b1;
        a_win   = ACH_W'(c);
      end
  end

  always_comb begin
    bus.alloc_req_rdy = '0;
    for (int c = 0; c < int'(NUM_ALLOC_CH); c++)
      bus.alloc_req_rdy[c] = a_found && (a_win == ACH_W'(c));
  end

  always_comb begin
    f_found = 1'b0;
    f_win   = '0;
    for (int c = 0; c < int'(NUM_FREE_CH); c++)
      if (!f_found && bus.free_req_val[c] && (ERR_CH_W'(c) >= f_ptr)) begin
        f_found = 1'b1;
        f_win   = ERR_CH_W'(c);
      end
    for (int c = 0; c < int'(NUM_FREE_CH); c++)
      if (!f_found && bus.free_req_val[c]) begin
        f_found = 1'b1;
        f_win   = ERR_CH_W'(c);
      end
  end

  always_comb begin
    bus.free_req_rdy = '0;
    f_addr           = '0;
    for (int c = 0; c < int'(NUM_FREE_CH); c++) begin
      bus.free_req_rdy[c] = f_found && (f_win == ERR_CH_W'(c));
      if (f_found && (f_win == ERR_CH_W'(c)))
        f_addr = bus.free_req_addr[c*ADDR_W +: ADDR_W];
    end
  end

  // Lowest-index free slab, taken from the pre-free bitmap.
  always_comb begin
    s_found  = 1'b0;
    s_onehot = '0;
    s_addr   = '0;
    for (int s = 0; s < int'(NUM_SLABS); s++)
      if (!s_found && !bitmap[s]) begin
        s_found     = 1'b1;
        s_onehot[s] = 1'b1;
        s_addr      = BASE + (ADDR_W'(s) << SHIFT);
      end
  end

  // Free legality: misaligned beats out-of-range beats double-free.
  always_comb begin
    {f_borrow, f_off} = {1'b0, f_addr} - {1'b0, BASE};
    f_slot = f_off >> SHIFT;
    f_mis  = (f_off & MASK) != '0;
    f_oor  = f_borrow || (f_slot >= NSLAB);
    f_hit  = '0;
    for (int s = 0; s < int'(NUM_SLABS); s++)
      f_hit[s] = (f_slot == ADDR_W'(s));
    f_dbl  = (f_hit & bitmap) == '0;
    f_bad  = f_found && (f_mis || f_oor || f_dbl);
    f_ok   = f_found && !(f_mis || f_oor || f_dbl);
    clr_mask = f_ok ? f_hit : '0;
    set_mask = (a_found && s_found) ? s_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitmap               <= '0;
      free_count           <= CNT_W'(NUM_SLABS);
      a_ptr                <= '0;
      f_ptr                <= '0;
      bus.alloc_resp_val   <= '0;
      bus.alloc_resp_error <= '0;
      bus.alloc_resp_addr  <= '0;
      free_err_val         <= 1'b0;
      free_err_cause       <= 2'b00;
      free_err_ch          <= '0;
    end else begin
      bitmap     <= (bitmap | set_mask) & ~clr_mask;
      free_count <= free_count - CNT_W'(a_found && s_found) + CNT_W'(f_ok);
      if (a_found)
        a_ptr <= (a_win == ACH_W'(NUM_ALLOC_CH - 1)) ? '0 : a_win + ACH_W'(1);
      if (f_found)
        f_ptr <= (f_win == ERR_CH_W'(NUM_FREE_CH - 1)) ? '0 : f_win + ERR_CH_W'(1);
      for (int c = 0; c < int'(NUM_ALLOC_CH); c++) begin
        if (bus.alloc_req_rdy[c]) begin
          bus.alloc_resp_val[c]                  <= 1'b1;
          bus.alloc_resp_error[c]                <= !s_found;
          bus.alloc_resp_addr[c*ADDR_W +: ADDR_W] <= s_found ? s_addr : '0;
        end else if (bus.alloc_resp_val[c] && bus.alloc_resp_rdy[c]) begin
          bus.alloc_resp_val[c]                  <= 1'b0;
          bus.alloc_resp_error[c]                <= 1'b0;
          bus.alloc_resp_addr[c*ADDR_W +: ADDR_W] <= '0;
        end
      end
      free_err_val   <= f_bad;
      free_err_cause <= !f_bad ? 2'b00 : f_mis ? 2'b01 : f_oor ? 2'b10 : 2'b11;
      free_err_ch    <= f_bad ? f_win : '0;
    end
  end
endmodule

// File: doc/slab_alloc_mc.md
Name: slab_alloc_mc

Overview:
Multi-channel slab allocator for the TCP engine buffer pool. It tracks NUM_SLABS fixed-size slabs with a per-slab allocated bitmap and serves NUM_ALLOC_CH allocate requesters and NUM_FREE_CH free requesters. Each side uses round-robin arbitration and a valid/ready handshake. Illegal frees (double-free, misaligned or out-of-range addresses) are detected and reported instead of corrupting state.

Parameters:
NUM_SLABS, 16, number of slabs (>=2)
SLAB_BYTES, 64, slab size in bytes; power of 2
BASE_ADDR, 0, byte address of slab 0; SLAB_BYTES-aligned
ADDR_W, 32, address width
NUM_ALLOC_CH, 2, allocate channels (>=1)
NUM_FREE_CH, 2, free channels (>=1)
CNT_W, clog2(NUM_SLABS+1), free-count width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
alloc_req_val  in  NUM_ALLOC_CH  per-channel allocate request
alloc_req_rdy  out  NUM_ALLOC_CH  per-channel request accepted (grant)
alloc_resp_val  out  NUM_ALLOC_CH  per-channel response valid
alloc_resp_error  out  NUM_ALLOC_CH  response carries no slab (pool empty)
alloc_resp_addr  out  NUM_ALLOC_CH*ADDR_W  response slab address, channel c in bits [c*ADDR_W +: ADDR_W]
alloc_resp_rdy  in  NUM_ALLOC_CH  consumer takes response
free_req_val  in  NUM_FREE_CH  per-channel free request
free_req_addr  in  NUM_FREE_CH*ADDR_W  slab address to free
free_req_rdy  out  NUM_FREE_CH  free accepted
free_err_val  out  1  one-cycle pulse: an accepted free was illegal
free_err_cause  out  2  01 misaligned, 10 out of range, 11 double-free
free_err_ch  out  clog2(NUM_FREE_CH)  channel of the illegal free
free_count  out  CNT_W  number of unallocated slabs

Behaviour:
- Reset (rst=0, async): bitmap all free; free_count=NUM_SLABS; all rdy/val outputs 0; resp_error 0; resp_addr 0; free_err_* 0; both round-robin pointers reset to channel 0.
- Alloc arbitration:
  - A channel is eligible when alloc_req_val[c]=1 and it has no pending response.
  - At most one grant per cycle, chosen round-robin starting at the channel after the last grant.
  - alloc_req_rdy[c] is combinational and high only for the granted channel; the handshake completes on the same edge.
- Alloc selection: at the grant edge the lowest-index free slab i is marked allocated. Next cycle: alloc_resp_val[c]=1, addr=BASE_ADDR+i*SLAB_BYTES, error=0. Latency is 1 cycle from grant to resp_val.
- Empty pool: the grant still occurs. The response has error=1 and addr=0, and the bitmap is unchanged.
- Response hold: resp_val, error and addr are held stable until alloc_resp_rdy[c]=1, then cleared the following cycle. The channel becomes eligible again in the cycle after the response is consumed; back-to-back on one channel is every 2 cycles minimum.
- Free arbitration: at most one accepted free per cycle, round-robin. free_req_rdy[c] is combinational for the winner.
- Free checks, on the accepted request, with offset=addr-BASE_ADDR:
  - offset not a multiple of SLAB_BYTES -> misaligned;
  - addr<BASE_ADDR or offset/SLAB_BYTES>=NUM_SLABS -> out of range;
  - slab already free -> double-free;
  - otherwise the slab bit is cleared.
  - An illegal free is consumed (rdy=1), leaves state unchanged, and pulses free_err_val with cause/ch in the next cycle.
- Simultaneous alloc and free in one cycle: the alloc chooses from the pre-free bitmap, so a freed slab is not reusable until the next cycle. free_count nets +1-1=0. If the pool was empty, the alloc returns error even though a free lands on the same edge.
- free_count updates on the same edge as the bitmap. It equals NUM_SLABS minus allocated bits at all times and never under- or overflows.
- Reset asserted mid-operation discards pending responses and restores the full pool.

Test Plan:
- Reset then ch0 alloc: resp_val[0] after 1 cycle, addr=0x0; second alloc addr=0x40; free_count 16->14.
- Both alloc channels requesting every cycle with resp_rdy=1: grants alternate ch0, ch1, ch0…; addresses 0x0,0x40,0x80 ascending; no slab returned twice.
- Allocate all 16 slabs; the 17th alloc returns error=1, addr=0, free_count=0. Free 0x80, then alloc returns 0x80.
- Hold alloc_resp_rdy[1]=0 for 5 cycles: resp stays stable and ch1 is not re-granted; ch0 keeps being served.
- Free 0x44 -> err cause 01; free 0x400 -> cause 10; free an already-free 0x0 -> cause 11. Each gives a 1-cycle pulse with the correct ch, and free_count is unchanged.
- Pool empty, free 0x0 and alloc in the same cycle: alloc errors, free_count=1. The next alloc returns 0x0.
